// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared funct3 size codes, FSM state type and load-extend helper for data_memory_hs
package dmem_pkg;

    localparam logic [2:0] SIZE_B  = 3'b000;
    localparam logic [2:0] SIZE_H  = 3'b001;
    localparam logic [2:0] SIZE_W  = 3'b010;
    localparam logic [2:0] SIZE_BU = 3'b100;
    localparam logic [2:0] SIZE_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic size_legal(input logic [2:0] size);
        size_legal = (size == SIZE_B) || (size == SIZE_H) || (size == SIZE_W) ||
                     (size == SIZE_BU) || (size == SIZE_HU);
    endfunction

    // Shift the addressed lane down to bit 0, then extend according to funct3.
    function automatic logic [31:0] load_extend(input logic [2:0] size, input logic [31:0] word,
                                                input logic [1:0] lane);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        case (size)
            SIZE_B:  load_extend = {{24{sh[7]}}, sh[7:0]};
            SIZE_BU: load_extend = {24'h0, sh[7:0]};
            SIZE_H:  load_extend = {{16{sh[15]}}, sh[15:0]};
            SIZE_HU: load_extend = {16'h0, sh[15:0]};
            SIZE_W:  load_extend = word;
            default: load_extend = 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane placement for stores, extension for loads, alignment check
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_raw,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    always_comb begin
        byte_en    = 4'b0000;
        wdata_lane = wdata;
        misaligned = 1'b0;
        case (size)
            SIZE_B, SIZE_BU: begin
                byte_en    = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
            end
            SIZE_H, SIZE_HU: begin
                byte_en    = 4'b0011 << addr_lo;
                wdata_lane = {2{wdata[15:0]}};
                misaligned = addr_lo[0];
            end
            SIZE_W: begin
                byte_en    = 4'b1111;
                misaligned = (addr_lo != 2'b00);
            end
            default: begin
                byte_en = 4'b0000;
            end
        endcase
    end

    assign rdata_ext = load_extend(size, rdata_raw, addr_lo);

endmodule

// File: rtl/data_memory_hs.sv
// rtl/data_memory_hs.sv - handshaked word RAM with wait states and RV32I sizing; debug port under DMEM_DEBUG_EN
module data_memory_hs
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    input  logic        debug_en,
    input  logic [31:0] debug_addr,
    input  logic [31:0] debug_data_in,
    input  logic        debug_write_en,
    output logic [31:0] debug_data_out,
    output logic        debug_ready
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [31:0] mem_q [DEPTH_WORDS];

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  size_q, size_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic        accept;
    logic        acc_fire;
    logic        acc_we;
    logic [31:0] acc_addr;
    logic [2:0]  acc_size;
    logic [31:0] acc_wdata;
    logic [31:0] acc_off;
    logic [AW-1:0] acc_idx;
    logic        acc_oor;
    logic        acc_err;
    logic [3:0]  byte_en;
    logic [31:0] wdata_lane;
    logic [31:0] rdata_ext;
    logic        misaligned;
    logic        core_we;
    logic        dbg_we;
    logic [31:0] dbg_off;
    logic [AW-1:0] dbg_idx;
    logic        unused_bits;

`ifdef DMEM_DEBUG_EN
    assign req_ready      = (state_q == ST_IDLE) && !debug_en;
    assign dbg_we         = debug_en && debug_write_en && (state_q == ST_IDLE);
    assign debug_ready    = dbg_we;
    assign debug_data_out = debug_en ? mem_q[dbg_idx] : 32'h0;
`else
    assign req_ready      = (state_q == ST_IDLE);
    assign dbg_we         = 1'b0;
    assign debug_ready    = 1'b0;
    assign debug_data_out = 32'h0;
`endif

    assign dbg_off     = debug_addr - BASE_ADDR;
    assign dbg_idx     = dbg_off[AW+1:2];
    assign unused_bits = ^{debug_en, debug_write_en, debug_data_in, dbg_off, acc_off[1:0]};

    assign accept = req_valid && req_ready;

    // With no wait states the access happens on the accept edge, straight from the request.
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_size  = req_size;
            acc_wdata = req_wdata;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_size  = size_q;
            acc_wdata = wdata_q;
        end
    end

    assign acc_off  = acc_addr - BASE_ADDR;
    assign acc_idx  = acc_off[AW+1:2];
    assign acc_oor  = ({2'b00, acc_off[31:2]} >= 32'(DEPTH_WORDS));
    assign acc_err  = !size_legal(acc_size) || misaligned || acc_oor;
    assign acc_fire = ((state_q == ST_IDLE) && accept && (WAIT_STATES == 0)) ||
                      ((state_q == ST_WAIT) && (cnt_q == 4'd0));
    assign core_we  = acc_fire && acc_we && !acc_err;

    dmem_lane_align u_align (
        .size       (acc_size),
        .addr_lo    (acc_addr[1:0]),
        .wdata      (acc_wdata),
        .rdata_raw  (mem_q[acc_idx]),
        .byte_en    (byte_en),
        .wdata_lane (wdata_lane),
        .rdata_ext  (rdata_ext),
        .misaligned (misaligned)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        size_d      = size_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'h0;
        rsp_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    size_d  = req_size;
                    wdata_d = req_wdata;
                    if (WAIT_STATES == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        cnt_d   = 4'(WAIT_STATES - 1);
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (acc_fire) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = acc_err;
            rsp_rdata_d = (acc_err || acc_we) ? 32'h0 : rdata_ext;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            size_q      <= 3'b000;
            wdata_q     <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // The array survives reset, but an edge seen while reset is held must not write.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (core_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (byte_en[b]) begin
                        mem_q[acc_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
                    end
                end
            end else if (dbg_we) begin
                mem_q[dbg_idx] <= debug_data_in;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_memory_hs.sv
// tb/tb_data_memory_hs.sv - directed self-checking bench for data_memory_hs (WAIT_STATES 1 and 0)
module tb_data_memory_hs;

`ifdef DMEM_DEBUG_EN
    localparam bit DBG = 1'b1;
`else
    localparam bit DBG = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        v1, v0;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_size;
    logic [31:0] req_wdata;
    logic        debug_en, debug_write_en;
    logic [31:0] debug_addr, debug_data_in;

    logic        r1_ready, r1_rsp_valid, r1_err, r1_dbg_ready;
    logic [31:0] r1_rdata, r1_dbg_out;
    logic        r0_ready, r0_rsp_valid, r0_err, r0_dbg_ready;
    logic [31:0] r0_rdata, r0_dbg_out;

    logic        sel0;
    logic        cur_ready, cur_rsp_valid, cur_err;
    logic [31:0] cur_rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    data_memory_hs #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0), .WAIT_STATES(1), .INIT_FILE("")) dut1 (
        .clk(clk), .reset(reset), .req_valid(v1), .req_ready(r1_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(r1_rsp_valid), .rsp_rdata(r1_rdata), .rsp_err(r1_err),
        .debug_en(debug_en), .debug_addr(debug_addr), .debug_data_in(debug_data_in),
        .debug_write_en(debug_write_en), .debug_data_out(r1_dbg_out), .debug_ready(r1_dbg_ready)
    );

    data_memory_hs #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0), .WAIT_STATES(0), .INIT_FILE("")) dut0 (
        .clk(clk), .reset(reset), .req_valid(v0), .req_ready(r0_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(r0_rsp_valid), .rsp_rdata(r0_rdata), .rsp_err(r0_err),
        .debug_en(debug_en), .debug_addr(debug_addr), .debug_data_in(debug_data_in),
        .debug_write_en(debug_write_en), .debug_data_out(r0_dbg_out), .debug_ready(r0_dbg_ready)
    );

    assign cur_ready     = sel0 ? r0_ready     : r1_ready;
    assign cur_rsp_valid = sel0 ? r0_rsp_valid : r1_rsp_valid;
    assign cur_err       = sel0 ? r0_err       : r1_err;
    assign cur_rdata     = sel0 ? r0_rdata     : r1_rdata;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic do_req(input bit s, input bit we, input logic [31:0] a, input logic [2:0] sz,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                          input string tag);
        int n;
        sel0 = s;
        @(negedge clk);
        n = 0;
        while (cur_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        req_we = we; req_addr = a; req_size = sz; req_wdata = wd;
        if (s) v0 = 1'b1; else v1 = 1'b1;
        @(posedge clk);
        #1;
        v0 = 1'b0; v1 = 1'b0;
        check_eq({tag, "_busy"}, 32'(cur_ready), 32'd0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cur_rsp_valid !== 1'b1 && n < 20);
        check_eq({tag, "_lat"}, n, s ? 32'd1 : 32'd2);
        check_eq({tag, "_err"}, 32'(cur_err), 32'(exp_err));
        check_eq({tag, "_rdata"}, cur_rdata, exp_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; v1 = 1'b0; v0 = 1'b0; sel0 = 1'b0;
        req_we = 1'b0; req_addr = 32'h0; req_size = 3'b010; req_wdata = 32'h0;
        debug_en = 1'b0; debug_write_en = 1'b0; debug_addr = 32'h0; debug_data_in = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("rst_ready1", 32'(r1_ready), 32'd1);
        check_eq("rst_ready0", 32'(r0_ready), 32'd1);
        check_eq("rst_valid", 32'(r1_rsp_valid), 32'd0);
        check_eq("rst_rdata", r1_rdata, 32'h0);
        check_eq("rst_err", 32'(r1_err), 32'd0);
        check_eq("rst_dbg_rdy", 32'(r1_dbg_ready), 32'd0);

        do_req(0, 1, 32'h0, 3'b010, 32'h11223344, 32'h0, 1'b0, "sw0");
        do_req(0, 1, 32'h0, 3'b000, 32'h000000AB, 32'h0, 1'b0, "sb0");
        do_req(0, 0, 32'h0, 3'b000, 32'h0, 32'hFFFFFFAB, 1'b0, "lb0");
        do_req(0, 0, 32'h0, 3'b100, 32'h0, 32'h000000AB, 1'b0, "lbu0");
        do_req(0, 0, 32'h3, 3'b000, 32'h0, 32'h00000011, 1'b0, "lb3");
        do_req(0, 0, 32'h2, 3'b001, 32'h0, 32'h00001122, 1'b0, "lh2");

        do_req(0, 1, 32'h8, 3'b010, 32'hDEADBEEF, 32'h0, 1'b0, "sw8");
        do_req(0, 1, 32'hA, 3'b001, 32'h0000C0DE, 32'h0, 1'b0, "shA");
        do_req(0, 0, 32'h8, 3'b010, 32'h0, 32'hC0DEBEEF, 1'b0, "lw8");
        do_req(0, 0, 32'hA, 3'b101, 32'h0, 32'h0000C0DE, 1'b0, "lhuA");
        do_req(0, 0, 32'hA, 3'b001, 32'h0, 32'hFFFFC0DE, 1'b0, "lhA");

        do_req(0, 0, 32'h6, 3'b010, 32'h0, 32'h0, 1'b1, "lw6_mis");
        do_req(0, 1, 32'h3, 3'b001, 32'h0000FFFF, 32'h0, 1'b1, "sh3_mis");
        do_req(0, 0, 32'h0, 3'b010, 32'h0, 32'h112233AB, 1'b0, "lw0_keep");
        do_req(0, 0, 32'h0, 3'b011, 32'h0, 32'h0, 1'b1, "sz011");
        do_req(0, 0, 32'h100, 3'b010, 32'h0, 32'h0, 1'b1, "lw_oor");
        do_req(0, 1, 32'h100, 3'b000, 32'h77, 32'h0, 1'b1, "sb_oor");

        do_req(0, 1, 32'hC, 3'b010, 32'h0BADF00D, 32'h0, 1'b0, "swC");
        @(negedge clk);
        debug_en = 1'b1; debug_addr = 32'hC; debug_data_in = 32'hCAFEBABE; debug_write_en = 1'b1;
        #1;
        check_eq("dbg_ready", 32'(r1_dbg_ready), DBG ? 32'd1 : 32'd0);
        check_eq("dbg_req_rdy", 32'(r1_ready), DBG ? 32'd0 : 32'd1);
        @(posedge clk);
        #1;
        debug_write_en = 1'b0;
        check_eq("dbg_out", r1_dbg_out, DBG ? 32'hCAFEBABE : 32'h0);
        debug_en = 1'b0;
        do_req(0, 0, 32'hC, 3'b010, 32'h0, DBG ? 32'hCAFEBABE : 32'h0BADF00D, 1'b0, "lwC");

        sel0 = 1'b0;
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h10; req_size = 3'b010; req_wdata = 32'h12345678;
        debug_addr = 32'h10; v1 = 1'b1;
        @(posedge clk);
        #1;
        v1 = 1'b0; debug_en = 1'b1;
        @(negedge clk);
        check_eq("s5_wait_rdy", 32'(r1_ready), 32'd0);
        @(negedge clk);
        check_eq("s5_rsp", 32'(r1_rsp_valid), 32'd1);
        check_eq("s5_err", 32'(r1_err), 32'd0);
        @(negedge clk);
        check_eq("s5_idle_rdy", 32'(r1_ready), DBG ? 32'd0 : 32'd1);
        check_eq("s5_dbg_out", r1_dbg_out, DBG ? 32'h12345678 : 32'h0);
        debug_en = 1'b0;
        #1;
        check_eq("s5_rdy_back", 32'(r1_ready), 32'd1);
        do_req(0, 0, 32'h10, 3'b010, 32'h0, 32'h12345678, 1'b0, "lw10");

        do_req(1, 1, 32'h4, 3'b010, 32'hA5A5F00F, 32'h0, 1'b0, "z_sw4");
        do_req(1, 0, 32'h4, 3'b010, 32'h0, 32'hA5A5F00F, 1'b0, "z_lw4");
        do_req(1, 0, 32'h5, 3'b000, 32'h0, 32'hFFFFFFF0, 1'b0, "z_lb5");
        do_req(1, 0, 32'h6, 3'b101, 32'h0, 32'h0000A5A5, 1'b0, "z_lhu6");
        do_req(1, 0, 32'h7, 3'b010, 32'h0, 32'h0, 1'b1, "z_lw7_mis");

        do_req(0, 1, 32'h14, 3'b010, 32'h55AA55AA, 32'h0, 1'b0, "sw14");
        sel0 = 1'b0;
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h14; req_size = 3'b010; req_wdata = 32'h99999999; v1 = 1'b1;
        @(posedge clk);
        #1;
        v1 = 1'b0; reset = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_wait_valid", 32'(r1_rsp_valid), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check_eq("rst_wait_rdy", 32'(r1_ready), 32'd1);
        do_req(0, 0, 32'h14, 3'b010, 32'h0, 32'h55AA55AA, 1'b0, "lw14_kept");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
